// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, occupancy count, and registered threshold flags.
// Optional sticky overflow/underflow flags when SYNC_FIFO_PARAM_ERR_FLAGS_EN is defined.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 45,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         write_enable,
  input  logic [WIDTH-1:0]             write_data,
  input  logic                         read_enable,
  output logic [WIDTH-1:0]             read_data,
  output logic                         full_flag,
  output logic                         empty_flag,
  output logic                         almost_full_flag,
  output logic                         almost_empty_flag,
`ifdef SYNC_FIFO_PARAM_ERR_FLAGS_EN
  input  logic                         err_clear,
  output logic                         overflow_flag,
  output logic                         underflow_flag,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   fill_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             wr_ok, rd_ok;

  // Explicit wrap so a non-power-of-2 depth never indexes past the last entry.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  assign wr_ok = write_enable & ~full_q;
  assign rd_ok = read_enable & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    if (wr_ok) begin
      wptr_d = next_ptr(wptr_q);
    end
    if (rd_ok) begin
      rptr_d  = next_ptr(rptr_q);
      rdata_d = mem_q[rptr_q];
    end
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CntW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Flags are derived from the next count so they line up with fill_count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      full_q   <= (count_d == CntW'(DEPTH));
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= CntW'(AF_LEVEL));
      aempty_q <= (count_d <= CntW'(AE_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= write_data;
    end
  end

  assign read_data         = rdata_q;
  assign full_flag         = full_q;
  assign empty_flag        = empty_q;
  assign almost_full_flag  = afull_q;
  assign almost_empty_flag = aempty_q;
  assign fill_count        = count_q;

`ifdef SYNC_FIFO_PARAM_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A new error event in the clear cycle wins over the clear.
  always_comb begin
    ovf_d = err_clear ? 1'b0 : ovf_q;
    udf_d = err_clear ? 1'b0 : udf_q;
    if (write_enable && full_q) begin
      ovf_d = 1'b1;
    end
    if (read_enable && empty_q) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow_flag  = ovf_q;
  assign underflow_flag = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
module tb_sync_fifo_param;

  localparam int unsigned W = 8;

  logic         clk;
  logic         resetn;
  logic         write_enable;
  logic [W-1:0] write_data;
  logic         read_enable;
  logic [W-1:0] read_data;
  logic         full_flag;
  logic         empty_flag;
  logic         almost_full_flag;
  logic         almost_empty_flag;
  logic [2:0]   fill_count;
`ifdef SYNC_FIFO_PARAM_ERR_FLAGS_EN
  logic         err_clear;
  logic         overflow_flag;
  logic         underflow_flag;
`endif

  int n_cmp;
  int n_err;

  sync_fifo_param #(
    .WIDTH    (W),
    .DEPTH    (5),
    .AF_LEVEL (4),
    .AE_LEVEL (1)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .write_enable      (write_enable),
    .write_data        (write_data),
    .read_enable       (read_enable),
    .read_data         (read_data),
    .full_flag         (full_flag),
    .empty_flag        (empty_flag),
    .almost_full_flag  (almost_full_flag),
    .almost_empty_flag (almost_empty_flag),
`ifdef SYNC_FIFO_PARAM_ERR_FLAGS_EN
    .err_clear         (err_clear),
    .overflow_flag     (overflow_flag),
    .underflow_flag    (underflow_flag),
`endif
    .fill_count        (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int cnt, input logic full, input logic empty,
                        input logic af, input logic ae);
    chk({tag, ".count"}, 32'(fill_count), 32'(cnt));
    chk({tag, ".full"}, 32'(full_flag), 32'(full));
    chk({tag, ".empty"}, 32'(empty_flag), 32'(empty));
    chk({tag, ".afull"}, 32'(almost_full_flag), 32'(af));
    chk({tag, ".aempty"}, 32'(almost_empty_flag), 32'(ae));
  endtask

  // Drive one cycle of requests; outputs are sampled 1 ns after the rising edge.
  task automatic cyc(input logic we, input logic [W-1:0] wd, input logic re);
    @(negedge clk);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    resetn       = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    read_enable  = 1'b0;
`ifdef SYNC_FIFO_PARAM_ERR_FLAGS_EN
    err_clear    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    chk_st("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset.rdata", 32'(read_data), 32'h0);
`ifdef SYNC_FIFO_PARAM_ERR_FLAGS_EN
    chk("reset.ovf", 32'(overflow_flag), 32'h0);
    chk("reset.udf", 32'(underflow_flag), 32'h0);
`endif

    // Fill: AF at 4, full at 5, AE only while count <= 1.
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 8'hA0 + 8'(k - 1), 1'b0);
      chk_st($sformatf("fill%0d", k), k, k == 5, 1'b0, k >= 4, k <= 1);
    end
    cyc(1'b1, 8'hFF, 1'b0);
    chk_st("drop_at_full", 5, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d.rdata", k), 32'(read_data), 32'hA0 + 32'(k - 1));
      chk_st($sformatf("drain%0d", k), 5 - k, 1'b0, k == 5, (5 - k) >= 4, (5 - k) <= 1);
    end

    // Wrap: 12 words through 5 entries.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) cyc(1'b1, 8'h10 + 8'(r * 3 + k), 1'b0);
      for (int k = 0; k < 3; k++) begin
        cyc(1'b0, 8'h00, 1'b1);
        chk($sformatf("wrap%0d_%0d", r, k), 32'(read_data), 32'h10 + 32'(r * 3 + k));
      end
    end
    chk_st("wrap_end", 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Simultaneous at full: read wins, write dropped.
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'hB0 + 8'(k), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    chk_st("both_full", 4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("both_full.rdata", 32'(read_data), 32'hB0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("after_full%0d", k), 32'(read_data), 32'hB0 + 32'(k));
    end
    chk_st("after_full_end", 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Simultaneous at empty: write wins, read_data holds.
    cyc(1'b1, 8'hC0, 1'b1);
    chk_st("both_empty", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("both_empty.rdata", 32'(read_data), 32'hB4);

    cyc(1'b1, 8'hC1, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0);
    cyc(1'b1, 8'hC3, 1'b1);
    chk_st("both_mid", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("both_mid.rdata", 32'(read_data), 32'hC0);

    // Asynchronous reset with three words held.
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_st("async_rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("async_rst.rdata", 32'(read_data), 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b1, 8'h55, 1'b0);
    chk_st("post_rst_wr", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_rd", 32'(read_data), 32'h55);
    chk_st("post_rst_end", 0, 1'b0, 1'b1, 1'b0, 1'b1);

`ifdef SYNC_FIFO_PARAM_ERR_FLAGS_EN
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'hD0 + 8'(k), 1'b0);
    chk("ovf_before", 32'(overflow_flag), 32'h0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_set", 32'(overflow_flag), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 32'(overflow_flag), 32'h1);
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b1);
    chk("udf_before", 32'(underflow_flag), 32'h0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("udf_set", 32'(underflow_flag), 32'h1);
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    chk("clr_ovf", 32'(overflow_flag), 32'h0);
    chk("clr_udf", 32'(underflow_flag), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
